// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared ISA definitions for the 16-bit, 16-register, 4-bit-opcode pipeline.
// Contents: opcode constants, the bubble opcode, and opcode classification
// helpers. The hazard unit uses these helpers, and the forwarding unit can
// reuse them.
package id_ex_hazard_reg_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // Last flag-writing opcode, and last opcode of the ALU group that reads Rt.
    localparam logic [3:0] OP_FLAG_LAST = 4'b0110;
    localparam logic [3:0] OP_RT_LAST   = 4'b0011;

    // opcode[3:2]==11 with Rd=0 is never a forwarding source.
    localparam logic [3:0] BUBBLE_OP = OP_B;

    function automatic logic is_reg_writer(input logic [3:0] op);
        return (op <= OP_LW) || (op == OP_LLB) || (op == OP_LHB) || (op == OP_PCS);
    endfunction

    function automatic logic is_flag_writer(input logic [3:0] op);
        return op <= OP_FLAG_LAST;
    endfunction

    function automatic logic uses_rs(input logic [3:0] op);
        return (op <= OP_SW) || (op == OP_BR);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        return (op <= OP_RT_LAST) || (op == OP_PADDSB) || (op == OP_SW);
    endfunction

    // LLB/LHB read-modify-write their destination, so Rd acts as a source.
    function automatic logic uses_rd_src(input logic [3:0] op);
        return (op == OP_LLB) || (op == OP_LHB);
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Bus between decode and EX and the ID/EX register.
// Signals: the ID payload (id_*), the EX/MEM producer view (ex_mem_*), the
// registered ID/EX payload (id_ex_*), the global hold, and the stall and
// stall_cnt results.
// Handshake: id_valid qualifies the id_* payload, and id_ex_valid qualifies
// the id_ex_* payload. stall is the back-pressure signal. While stall=1,
// PC and IF/ID must not update, so the same ID instruction is presented
// again on the next cycle. While hold=1, ID/EX keeps its contents.
// master = decode/pipeline side; slave = the ID/EX register.
interface id_ex_hazard_reg_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              hold;
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [3:0]        id_rs;
    logic [3:0]        id_rt;
    logic [3:0]        id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              ex_mem_valid;
    logic [3:0]        ex_mem_opcode;
    logic [3:0]        ex_mem_rd;
    logic              id_ex_valid;
    logic [3:0]        id_ex_opcode;
    logic [3:0]        id_ex_rs;
    logic [3:0]        id_ex_rt;
    logic [3:0]        id_ex_rd;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [DATA_W-1:0] id_ex_rs_data;
    logic [DATA_W-1:0] id_ex_rt_data;
    logic [DATA_W-1:0] id_ex_imm;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output hold, id_valid, id_opcode, id_rs, id_rt, id_rd, id_ctrl,
               id_rs_data, id_rt_data, id_imm, ex_mem_valid, ex_mem_opcode, ex_mem_rd,
        input  id_ex_valid, id_ex_opcode, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm, stall, stall_cnt
    );

    modport slave (
        input  hold, id_valid, id_opcode, id_rs, id_rt, id_rd, id_ctrl,
               id_rs_data, id_rt_data, id_imm, ex_mem_valid, ex_mem_opcode, ex_mem_rd,
        output id_ex_valid, id_ex_opcode, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm, stall, stall_cnt
    );
endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Combinational hazard detector. It raises hazard for the cases that
// forwarding cannot cover.
// Inputs: the ID instruction (id_valid, id_opcode, id_rs, id_rt, id_rd),
// the ID/EX occupant (ex_valid, ex_opcode, ex_rd), and the EX/MEM occupant
// (mem_valid, mem_opcode, mem_rd).
// Outputs: hazard, plus the individual causes (load_use, br_reg, br_flags),
// which are exposed for observation.
module id_ex_hazard_reg_hazard_detect
    import id_ex_hazard_reg_pkg::*;
(
    input  logic       id_valid,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic [3:0] id_rd,
    input  logic       ex_valid,
    input  logic [3:0] ex_opcode,
    input  logic [3:0] ex_rd,
    input  logic       mem_valid,
    input  logic [3:0] mem_opcode,
    input  logic [3:0] mem_rd,
    output logic       load_use,
    output logic       br_reg,
    output logic       br_flags,
    output logic       hazard
);
    logic [3:0] rs_spec;
    logic       rs_use;
    logic       rt_use;
    logic       is_branch;

    always_comb begin
        rs_spec   = uses_rd_src(id_opcode) ? id_rd : id_rs;
        rs_use    = uses_rs(id_opcode) | uses_rd_src(id_opcode);
        // Store data reaches MEM through MEM-to-MEM forwarding, so an Rt
        // match on SW does not need a load-use stall.
        rt_use    = uses_rt(id_opcode) & (id_opcode != OP_SW);
        is_branch = (id_opcode == OP_B) | (id_opcode == OP_BR);

        load_use = ex_valid & (ex_opcode == OP_LW) & (ex_rd != 4'd0)
                 & ((rs_use & (rs_spec == ex_rd)) | (rt_use & (id_rt == ex_rd)));

        // BR resolves in ID, so its target register must already be final.
        br_reg = (id_opcode == OP_BR) & (id_rs != 4'd0)
               & ((ex_valid & is_reg_writer(ex_opcode) & (ex_rd == id_rs))
                | (mem_valid & (mem_opcode == OP_LW) & (mem_rd == id_rs)));

        br_flags = is_branch & ex_valid & is_flag_writer(ex_opcode);

        hazard = id_valid & (load_use | br_reg | br_flags);
    end
endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with hazard detection.
// Ports: clk, rst (synchronous active-high), and bus (slave modport of
// id_ex_hazard_reg_if).
// Update priority: reset, then hold (freeze), then hazard (load a bubble and
// bump the saturating stall counter), then capture of the ID payload.
// stall = hazard | hold, and is purely combinational.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_hazard_reg_if.slave  bus
);
    logic              valid_q;
    logic [3:0]        opcode_q;
    logic [3:0]        rs_q;
    logic [3:0]        rt_q;
    logic [3:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [CNT_W-1:0]  cnt_q;

    logic hazard;
    logic load_use;
    logic br_reg;
    logic br_flags;

    id_ex_hazard_reg_hazard_detect u_hazard_detect (
        .id_valid   (bus.id_valid),
        .id_opcode  (bus.id_opcode),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_rd      (bus.id_rd),
        .ex_valid   (valid_q),
        .ex_opcode  (opcode_q),
        .ex_rd      (rd_q),
        .mem_valid  (bus.ex_mem_valid),
        .mem_opcode (bus.ex_mem_opcode),
        .mem_rd     (bus.ex_mem_rd),
        .load_use   (load_use),
        .br_reg     (br_reg),
        .br_flags   (br_flags),
        .hazard     (hazard)
    );

    assign bus.stall = hazard | bus.hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= BUBBLE_OP;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else if (bus.hold) begin
            // Multi-cycle memory freeze: keep everything, including the counter.
        end else if (hazard) begin
            valid_q   <= 1'b0;
            opcode_q  <= BUBBLE_OP;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            // The ID payload is captured even when id_valid=0, tagged invalid.
            valid_q   <= bus.id_valid;
            opcode_q  <= bus.id_opcode;
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            rd_q      <= bus.id_rd;
            ctrl_q    <= bus.id_ctrl;
            rs_data_q <= bus.id_rs_data;
            rt_data_q <= bus.id_rt_data;
            imm_q     <= bus.id_imm;
        end
    end

    assign bus.id_ex_valid   = valid_q;
    assign bus.id_ex_opcode  = opcode_q;
    assign bus.id_ex_rs      = rs_q;
    assign bus.id_ex_rt      = rt_q;
    assign bus.id_ex_rd      = rd_q;
    assign bus.id_ex_ctrl    = ctrl_q;
    assign bus.id_ex_rs_data = rs_data_q;
    assign bus.id_ex_rt_data = rt_data_q;
    assign bus.id_ex_imm     = imm_q;
    assign bus.stall_cnt     = cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Testbench for id_ex_hazard_reg. It drives directed scenarios, randomized
// traffic and a counter-saturation run, and compares the DUT against a
// behavioural model of the pipeline register.
module tb_id_ex_hazard_reg;
    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_LW = 4'd8, T_SW = 4'd9;
    localparam logic [3:0] T_LLB = 4'd10, T_B = 4'd12, T_BR = 4'd13;
    localparam int W = 89;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_hazard_reg_if bus();

    id_ex_hazard_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Model of the ID/EX contents
    bit        m_valid;
    bit [3:0]  m_op, m_rs, m_rt, m_rd;
    bit [7:0]  m_ctrl;
    bit [15:0] m_rsd, m_rtd, m_imm, m_cnt;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hazard worked out from the rules: gather the registers the ID
    // instruction needs before EX, then check them against the producers.
    function automatic bit model_hazard();
        int  srcs[$];
        bit  lw_use = 0, br_reg = 0, flags = 0, ex_writes;
        int  op = int'(bus.id_opcode);
        if (!bus.id_valid) return 0;
        if (op <= 9 || op == 13) srcs.push_back(int'(bus.id_rs));
        if (op == 10 || op == 11) srcs.push_back(int'(bus.id_rd));
        if (op <= 3 || op == 7) srcs.push_back(int'(bus.id_rt));  // SW store data excluded
        if (m_valid && m_op == T_LW && m_rd != 0)
            foreach (srcs[i]) if (srcs[i] == int'(m_rd)) lw_use = 1;
        ex_writes = (m_op <= 8) || m_op == 10 || m_op == 11 || m_op == 14;
        if (op == 13 && bus.id_rs != 0)
            br_reg = (m_valid && ex_writes && m_rd == bus.id_rs) ||
                     (bus.ex_mem_valid && bus.ex_mem_opcode == T_LW && bus.ex_mem_rd == bus.id_rs);
        flags = (op == 12 || op == 13) && m_valid && m_op <= 6;
        return lw_use | br_reg | flags;
    endfunction

    task automatic model_step(input bit hz);
        if (rst) begin
            {m_valid, m_rs, m_rt, m_rd, m_ctrl, m_rsd, m_rtd, m_imm, m_cnt} = '0;
            m_op = 4'hC;
        end else if (bus.hold) begin
        end else if (hz) begin
            {m_valid, m_rs, m_rt, m_rd, m_ctrl, m_rsd, m_rtd, m_imm} = '0;
            m_op = 4'hC;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = bus.id_valid; m_op = bus.id_opcode;
            m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
            m_ctrl = bus.id_ctrl; m_rsd = bus.id_rs_data; m_rtd = bus.id_rt_data; m_imm = bus.id_imm;
        end
        exp_q.push_back({m_valid, m_op, m_rs, m_rt, m_rd, m_ctrl, m_rsd, m_rtd, m_imm, m_cnt});
    endtask

    // One clock: check stall mid-cycle, let the edge pass, then check the registers.
    task automatic cycle(input bit chk);
        bit hz;
        logic [W-1:0] e;
        #1;
        hz = model_hazard();
        if (chk) check("stall", bus.stall, hz | bus.hold);
        model_step(hz);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (chk)
            check("id_ex", {bus.id_ex_valid, bus.id_ex_opcode, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd,
                            bus.id_ex_ctrl, bus.id_ex_rs_data, bus.id_ex_rt_data, bus.id_ex_imm,
                            bus.stall_cnt}, e);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [3:0] op, rs, rt, rd);
        bus.id_valid   = v;
        bus.id_opcode  = op;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_ctrl    = 8'($urandom);
        bus.id_rs_data = 16'($urandom);
        bus.id_rt_data = 16'($urandom);
        bus.id_imm     = 16'($urandom);
    endtask

    task automatic exmem(input bit v, input logic [3:0] op, rd);
        bus.ex_mem_valid  = v;
        bus.ex_mem_opcode = op;
        bus.ex_mem_rd     = rd;
    endtask

    task automatic stall_now(input string tag, input logic exp);
        #1 check(tag, bus.stall, exp);
    endtask

    initial begin
        bit [15:0] c0;
        rst = 1'b1;
        bus.hold = 1'b0;
        drive(0, T_ADD, 0, 0, 0);
        exmem(0, T_ADD, 0);
        @(negedge clk);

        // Reset state
        cycle(1);
        check("rst_opcode", bus.id_ex_opcode, 4'hC);
        check("rst_valid", bus.id_ex_valid, 0);
        check("rst_cnt", bus.stall_cnt, 0);
        rst = 1'b0;

        // LW R3 then ADD R4,R3,R5: one bubble, then capture
        drive(1, T_LW, 1, 0, 3); cycle(1);
        drive(1, T_ADD, 3, 5, 4);
        stall_now("lw_use_stall", 1);
        cycle(1);
        check("bubble_valid", bus.id_ex_valid, 0);
        check("bubble_op", bus.id_ex_opcode, 4'hC);
        check("bubble_rd", bus.id_ex_rd, 0);
        stall_now("lw_use_clear", 0);
        cycle(1);
        check("add_captured", {bus.id_ex_valid, bus.id_ex_opcode, bus.id_ex_rd}, {1'b1, T_ADD, 4'd4});
        check("cnt_one", bus.stall_cnt, 1);

        // Store data from a load needs no stall; a load feeding the base does
        drive(1, T_LW, 1, 0, 3); cycle(1);
        drive(1, T_SW, 7, 3, 0);
        stall_now("sw_data_nostall", 0);
        cycle(1);
        check("sw_captured", {bus.id_ex_valid, bus.id_ex_opcode}, {1'b1, T_SW});
        drive(1, T_LW, 1, 0, 3); cycle(1);
        drive(1, T_SW, 3, 6, 0);
        stall_now("sw_base_stall", 1);
        cycle(1); cycle(1);

        // ADD R2 then BR R2: one bubble
        drive(1, T_ADD, 1, 1, 2); cycle(1);
        drive(1, T_BR, 2, 0, 0);
        stall_now("br_alu_stall", 1);
        cycle(1); cycle(1);

        // LW R2 then BR R2: two bubbles while the load moves to EX/MEM
        drive(1, T_LW, 1, 0, 2); cycle(1);
        c0 = m_cnt;
        drive(1, T_BR, 2, 0, 0);
        cycle(1);
        exmem(1, T_LW, 2);
        stall_now("br_lw_mem_stall", 1);
        cycle(1);
        exmem(0, T_ADD, 0);
        stall_now("br_lw_done", 0);
        cycle(1);
        check("br_lw_cnt", bus.stall_cnt, 16'(c0 + 16'd2));

        // Flags: SUB then B stalls; LLB then B does not
        drive(1, T_SUB, 1, 1, 5); cycle(1);
        drive(1, T_B, 0, 0, 0);
        stall_now("b_flag_stall", 1);
        cycle(1); cycle(1);
        drive(1, T_LLB, 0, 0, 6); cycle(1);
        drive(1, T_B, 0, 0, 0);
        stall_now("b_llb_nostall", 0);
        cycle(1);

        // Hold over an active load-use hazard
        drive(1, T_LW, 1, 0, 3); cycle(1);
        c0 = m_cnt;
        drive(1, T_ADD, 3, 5, 4);
        bus.hold = 1'b1;
        repeat (3) begin
            stall_now("hold_stall", 1);
            cycle(1);
            check("hold_frozen", {bus.id_ex_opcode, bus.id_ex_rd, bus.stall_cnt}, {T_LW, 4'd3, c0});
        end
        bus.hold = 1'b0;
        cycle(1);
        check("hold_bubble", bus.id_ex_valid, 0);
        cycle(1);
        check("hold_consumer", {bus.id_ex_valid, bus.id_ex_opcode}, {1'b1, T_ADD});

        // Reset during a pending stall
        drive(1, T_LW, 1, 0, 3); cycle(1);
        drive(1, T_ADD, 3, 5, 4);
        rst = 1'b1;
        stall_now("rst_mid_stall", 1);
        cycle(1);
        check("rst_mid_state", {bus.id_ex_valid, bus.id_ex_opcode, bus.stall_cnt}, {1'b0, 4'hC, 16'd0});
        rst = 1'b0;

        // Randomized traffic with small register numbers to make hazards common
        repeat (800) begin
            drive($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            exmem($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? T_LW : 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)));
            bus.hold = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            cycle(1);
        end
        rst = 1'b0;
        bus.hold = 1'b0;

        // Saturation: a BR stuck behind a load in EX/MEM keeps stalling
        rst = 1'b1; drive(0, T_ADD, 0, 0, 0); exmem(0, T_ADD, 0); cycle(1);
        rst = 1'b0;
        exmem(1, T_LW, 2);
        drive(1, T_BR, 2, 0, 0);
        repeat (65540) cycle(0);
        cycle(1);
        check("cnt_saturated", bus.stall_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- Combined ID/EX pipeline register and hazard-detection unit for the 16-bit, 16-register, 4-bit-opcode pipeline.
- Sits between decode and EX, directly upstream of the forwarding unit.
- Supplies the registered Rs/Rt/Rd/opcode that forwarding consumes.
- Detects hazards that forwarding cannot cover (load-use, and ID-resolved branches needing results or flags not yet available), freezes PC and IF/ID, and injects bubbles.

Parameters:
DATA_W, 16, width of register operands and immediate
CTRL_W, 8, width of opaque decoded control bundle (RegWrite, MemRead, MemWrite, ... carried unchanged)
CNT_W, 16, width of stall statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hold  in  1  global freeze from multi-cycle memory; ID/EX retains contents
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  4  ID opcode
id_rs, id_rt, id_rd  in  4 each  ID register specifiers
id_ctrl  in  CTRL_W  ID control bundle
id_rs_data, id_rt_data, id_imm  in  DATA_W each  ID operand payload
ex_mem_valid  in  1  EX/MEM holds a real instruction
ex_mem_opcode  in  4  EX/MEM opcode
ex_mem_rd  in  4  EX/MEM destination
id_ex_valid  out  1  registered valid
id_ex_opcode  out  4  registered opcode
id_ex_rs, id_ex_rt, id_ex_rd  out  4 each  registered specifiers
id_ex_ctrl  out  CTRL_W  registered control
id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W each  registered payload
stall  out  1  combinational; PC and IF/ID must not update
stall_cnt  out  CNT_W  saturating count of hazard-bubble cycles

Behaviour:
- Opcodes: ADD 0000 … PADDSB 0111, LW 1000, SW 1001, LLB 1010, LHB 1011, B 1100, BR 1101, PCS 1110, HLT 1111.
- Flag writers: opcodes 0000–0110.
- Register writers: opcodes 0000–1000, 1010, 1011, 1110.
- Source usage:
  - Rs used by 0000–1001, BR.
  - Rt used by 0000–0011, 0111, SW (as store data).
  - LLB/LHB use Rd as source (treated as Rs use of id_rd).
- Hazard conditions: hazard = id_valid & any of the following.
  - H1 load-use: id_ex_valid, id_ex_opcode==LW, id_ex_rd!=0, and id_ex_rd matches a used ID source.
    - Exception: ID is SW and the only match is Rt (store data). This is covered by MEM-to-MEM forwarding, so no stall.
  - H2 BR register: ID opcode BR and id_rs!=0 and either:
    - id_ex_valid, id_ex_opcode is a register writer, and id_ex_rd==id_rs; or
    - ex_mem_valid, ex_mem_opcode==LW, and ex_mem_rd==id_rs.
  - H3 flags: ID opcode B or BR, id_ex_valid, and id_ex_opcode is a flag writer.
- stall = hazard | hold (combinational, no latency).
- Register update on posedge, priority highest first:
  1. rst: all outputs 0 except id_ex_opcode=4'b1100 (bubble encoding); id_ex_valid=0; stall_cnt=0.
  2. hold: all registers retain value; stall_cnt unchanged.
  3. hazard: load bubble: valid=0, opcode=4'b1100, rs/rt/rd=0, ctrl=0, data=0. stall_cnt increments, saturating at all-ones.
  4. otherwise: capture all id_* fields; id_ex_valid=id_valid.
- Bubble encoding never forwards: opcode[3:2]==11 and Rd=0.
- Hazard persists each cycle until the producer advances. LW-use costs exactly 1 bubble; BR-after-LW costs 2.
- rst asserted mid-stall: next cycle is the reset state; stall follows its combinational inputs.
- hold and hazard together: hold wins; no bubble inserted, counter frozen, stall=1.
- id_valid=0: never a hazard; the invalid instruction is captured as-is with valid=0.

Decomposition:
- Shared package (cpu_pkg): opcode localparams, BUBBLE_OP, and helper functions is_reg_writer, is_flag_writer, uses_rs, uses_rt. The forwarding unit reuses these.
- Sub-module hazard_detect: purely combinational, producing hazard. The top holds registers, priority mux and counter.

Test Plan:
- LW R3 then ADD R4,R3,R5 -> stall=1 one cycle; ID/EX shows bubble (valid=0, op=1100, rd=0); next cycle ADD captured; stall_cnt=1.
- LW R3 then SW R3,R6 (data reg Rt=R3) -> stall=0, SW captured immediately. LW R3 then SW R7,R3 (base) -> one bubble.
- ADD R2 (ID/EX), BR with rs=R2 in ID -> 1 bubble. LW R2 in EX/MEM, BR rs=R2 in ID -> further bubble. Total stall_cnt +2 for LW→BR back-to-back.
- SUB in ID/EX, B in ID -> 1 bubble. LLB in ID/EX, B in ID -> no stall.
- hold=1 during an active LW-use hazard for 3 cycles -> ID/EX frozen, stall=1, stall_cnt unchanged; after hold drops, one bubble, then consumer captured.
- rst asserted while bubble pending -> next cycle all outputs 0, opcode=1100, stall_cnt=0. Drive 2^16 hazard cycles -> stall_cnt saturates at 16'hFFFF.
